// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: monitors a multiplexed 4-digit FND scan bus and
// rebuilds settled, complete frames as BCD, binary value and dp flags.
module fnd_scan_decoder #(
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  fnd_com,
   input  logic [7:0]  fnd_data,
   output logic [15:0] digit_bcd,
   output logic [3:0]  dp,
   output logic [13:0] value,
   output logic        frame_valid,
   output logic        value_changed,
   output logic        seg_err,
   output logic        com_err,
   output logic        stale,
   output logic [7:0]  err_cnt
);

   localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_SETTLE, S_EVAL, S_HOLD} state_e;

   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h40:   seg_decode = 5'h10;
         7'h79:   seg_decode = 5'h11;
         7'h24:   seg_decode = 5'h12;
         7'h30:   seg_decode = 5'h13;
         7'h19:   seg_decode = 5'h14;
         7'h12:   seg_decode = 5'h15;
         7'h02:   seg_decode = 5'h16;
         7'h78:   seg_decode = 5'h17;
         7'h00:   seg_decode = 5'h18;
         7'h10:   seg_decode = 5'h19;
         default: seg_decode = 5'h00;
      endcase
   endfunction

   state_e        state_q, state_d;
   logic [11:0]   pair_q, pair_d, snap_q, snap_d;
   logic [SW-1:0] stab_q, stab_d;
   logic          same;
   logic [15:0]   dig_q, dig_d;
   logic [3:0]    dpr_q, dpr_d, seen_q, seen_d;
   logic          seg_err_q, seg_err_d, com_err_q, com_err_d;
   logic          frame_d, frame_valid_q;
   logic [15:0]   digit_bcd_q, digit_bcd_d;
   logic [3:0]    dp_q, dp_d;
   logic [13:0]   value_q, value_d, prev_value_q, prev_value_d, bin;
   logic          value_changed_q, value_changed_d;
   logic          first_q, first_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          stale_q, stale_d;
   logic          com_ok;
   logic [1:0]    idx;
   logic [4:0]    dec;

   // Stability is judged on the registered pair against what it is about to become.
   always_comb begin
      pair_d = {fnd_com, fnd_data};
      same   = (pair_d == pair_q);
      stab_d = '0;
      if (same) begin
         stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      case (state_q)
         S_SETTLE: if (stab_q == STAB_MAX) state_d = S_EVAL;
         S_EVAL:   state_d = S_HOLD;
         S_HOLD:   if (!same || stab_q != STAB_MAX) state_d = S_SETTLE;
         default:  state_d = S_SETTLE;
      endcase
      // Freeze the settled pair so a change arriving with EVAL is not judged.
      if (state_d == S_EVAL) snap_d = pair_q;
   end

   assign frame_d = (seen_q == 4'hF);

   always_comb begin
      dig_d     = dig_q;
      dpr_d     = dpr_q;
      seen_d    = frame_d ? 4'h0 : seen_q;
      seg_err_d = 1'b0;
      com_err_d = 1'b0;
      com_ok    = 1'b0;
      idx       = 2'd0;
      dec       = seg_decode(snap_q[6:0]);
      if (state_q == S_EVAL) begin
         case (snap_q[11:8])
            4'b1110: begin com_ok = 1'b1; idx = 2'd0; end
            4'b1101: begin com_ok = 1'b1; idx = 2'd1; end
            4'b1011: begin com_ok = 1'b1; idx = 2'd2; end
            4'b0111: begin com_ok = 1'b1; idx = 2'd3; end
            4'b1111: com_ok = 1'b0;
            default: com_err_d = 1'b1;
         endcase
         if (com_ok) begin
            if (dec[4]) begin
               dig_d[{idx, 2'b00} +: 4] = dec[3:0];
               dpr_d[idx]  = ~snap_q[7];
               seen_d[idx] = 1'b1;
            end else begin
               seg_err_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bin = 14'(dig_q[15:12]) * 14'd1000 + 14'(dig_q[11:8]) * 14'd100
          + 14'(dig_q[7:4]) * 14'd10 + 14'(dig_q[3:0]);
      digit_bcd_d     = digit_bcd_q;
      dp_d            = dp_q;
      value_d         = value_q;
      value_changed_d = 1'b0;
      prev_value_d    = prev_value_q;
      first_d         = first_q;
      if (frame_d) begin
         digit_bcd_d     = dig_q;
         dp_d            = dpr_q;
         value_d         = bin;
         value_changed_d = (bin != prev_value_q) | first_q;
         prev_value_d    = bin;
         first_d         = 1'b0;
      end
      err_cnt_d = err_cnt_q;
      if ((seg_err_d || com_err_d) && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      tmo_d   = tmo_q;
      stale_d = stale_q;
      if (frame_d) begin
         tmo_d   = '0;
         stale_d = 1'b0;
      end else if (tmo_q == TMO_MAX) begin
         stale_d = 1'b1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_SETTLE;
         pair_q          <= '0;
         snap_q          <= '0;
         stab_q          <= '0;
         dig_q           <= '0;
         dpr_q           <= '0;
         seen_q          <= '0;
         seg_err_q       <= 1'b0;
         com_err_q       <= 1'b0;
         frame_valid_q   <= 1'b0;
         digit_bcd_q     <= '0;
         dp_q            <= '0;
         value_q         <= '0;
         value_changed_q <= 1'b0;
         prev_value_q    <= '0;
         first_q         <= 1'b1;
         err_cnt_q       <= '0;
         tmo_q           <= '0;
         stale_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         pair_q          <= pair_d;
         snap_q          <= snap_d;
         stab_q          <= stab_d;
         dig_q           <= dig_d;
         dpr_q           <= dpr_d;
         seen_q          <= seen_d;
         seg_err_q       <= seg_err_d;
         com_err_q       <= com_err_d;
         frame_valid_q   <= frame_d;
         digit_bcd_q     <= digit_bcd_d;
         dp_q            <= dp_d;
         value_q         <= value_d;
         value_changed_q <= value_changed_d;
         prev_value_q    <= prev_value_d;
         first_q         <= first_d;
         err_cnt_q       <= err_cnt_d;
         tmo_q           <= tmo_d;
         stale_q         <= stale_d;
      end
   end

   assign digit_bcd     = digit_bcd_q;
   assign dp            = dp_q;
   assign value         = value_q;
   assign frame_valid   = frame_valid_q;
   assign value_changed = value_changed_q;
   assign seg_err       = seg_err_q;
   assign com_err       = com_err_q;
   assign stale         = stale_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder: directed scans against a frame-level model
// of the decoder, plus literal expectations for each scenario.
module tb_fnd_scan_decoder;

   localparam int TMO = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  fnd_com = 4'hF;
   logic [7:0]  fnd_data = 8'hFF;
   logic [15:0] digit_bcd;
   logic [3:0]  dp;
   logic [13:0] value;
   logic        frame_valid, value_changed, seg_err, com_err, stale;
   logic [7:0]  err_cnt;

   fnd_scan_decoder #(.SETTLE_CYC(4), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .fnd_com(fnd_com), .fnd_data(fnd_data),
      .digit_bcd(digit_bcd), .dp(dp), .value(value),
      .frame_valid(frame_valid), .value_changed(value_changed),
      .seg_err(seg_err), .com_err(com_err), .stale(stale),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  dp;
      int          val;
      logic        vc;
   } frame_t;

   logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   frame_t exp_q[$];
   int  m_prev = 0;
   bit  m_first = 1'b1;
   int  n_chk = 0, n_pass = 0;
   int  cyc = 0, fv_cyc = 0, n_frames = 0, n_seg = 0, n_com = 0;
   logic last_vc = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic slot(input logic [3:0] c, input logic [7:0] d,
                       input int n);
      fnd_com  = c;
      fnd_data = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input int d3, input int d2, input int d1,
                       input int d0, input logic [3:0] dpm,
                       input bit glitch);
      int dg[4];
      frame_t f;
      logic [7:0] s, w;
      dg = '{d0, d1, d2, d3};
      f.bcd = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
      f.dp  = dpm;
      f.val = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
      f.vc  = m_first || (f.val != m_prev);
      m_prev  = f.val;
      m_first = 1'b0;
      exp_q.push_back(f);
      for (int k = 0; k < 4; k++) begin
         s = seg_tbl[dg[k]];
         s[7] = ~dpm[k];
         if (glitch) begin
            w = seg_tbl[(dg[k] + 3) % 10];
            slot(4'hF, 8'hFF, 5);
            slot(~(4'b0001 << k), w, 3);
         end
         slot(~(4'b0001 << k), s, 20);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fnd_com = 4'hF;
      fnd_data = 8'hFF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_first = 1'b1;
      m_prev = 0;
      exp_q.delete();
   endtask

   // Per-cycle compare against the frame-level model.
   initial begin
      frame_t f;
      int since, m_err, conv;
      logic [15:0] h_bcd;
      logic [3:0]  h_dp;
      logic [13:0] h_val;
      since = 0; m_err = 0;
      h_bcd = '0; h_dp = '0; h_val = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            since = 0; m_err = 0;
            h_bcd = '0; h_dp = '0; h_val = '0;
            chk("rst_outputs", {digit_bcd, dp, value, frame_valid,
                value_changed, seg_err, com_err, stale, err_cnt}, 64'd0);
         end else begin
            if (frame_valid) begin
               n_frames++;
               fv_cyc = cyc;
               last_vc = value_changed;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL frame_unexpected: got value %0d", value);
               end else begin
                  f = exp_q.pop_front();
                  chk("frame_bcd", digit_bcd, f.bcd);
                  chk("frame_dp", dp, f.dp);
                  chk("frame_value", value, f.val);
                  chk("frame_changed", value_changed, f.vc);
                  h_bcd = f.bcd; h_dp = f.dp; h_val = 14'(f.val);
               end
               since = 0;
            end else begin
               chk("hold", {digit_bcd, dp, value, value_changed},
                   {h_bcd, h_dp, h_val, 1'b0});
               if (since < TMO) since++;
            end
            conv = digit_bcd[15:12] * 1000 + digit_bcd[11:8] * 100
                 + digit_bcd[7:4] * 10 + digit_bcd[3:0];
            chk("value_arith", value, conv);
            chk("err_exclusive", seg_err & com_err, 0);
            if (seg_err || com_err) m_err = (m_err < 255) ? m_err + 1 : 255;
            n_seg += int'(seg_err);
            n_com += int'(com_err);
            chk("err_cnt", err_cnt, m_err);
            chk("stale", stale, since >= TMO);
         end
      end
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      do_reset();
      chk("t0_value", value, 0);
      chk("t0_bcd", digit_bcd, 0);

      scan(4, 3, 2, 1, 4'b0000, 1'b0);
      slot(4'hF, 8'hFF, 10);
      chk("t1_bcd", digit_bcd, 16'h4321);
      chk("t1_value", value, 4321);
      chk("t1_changed", last_vc, 1);
      chk("t1_frames", n_frames, 1);

      scan(4, 3, 2, 1, 4'b0000, 1'b0);
      chk("t2_same_changed", last_vc, 0);
      chk("t2_frames", n_frames, 2);
      scan(4, 3, 2, 5, 4'b0100, 1'b0);
      slot(4'hF, 8'hFF, 10);
      chk("t2_value", value, 4325);
      chk("t2_dp", dp, 4'b0100);
      chk("t2_changed", last_vc, 1);

      scan(9, 8, 7, 6, 4'b0000, 1'b1);
      slot(4'hF, 8'hFF, 10);
      chk("t3_value", value, 9876);
      chk("t3_bcd", digit_bcd, 16'h9876);
      chk("t3_no_err", err_cnt, 0);

      slot(4'hE, 8'hFF, 20);
      slot(4'hF, 8'hFF, 5);
      chk("t4_seg_cnt", err_cnt, 1);
      chk("t4_seg_pulses", n_seg, 1);
      slot(4'b1100, 8'hF9, 20);
      slot(4'hF, 8'hFF, 5);
      chk("t4_com_cnt", err_cnt, 2);
      chk("t4_com_pulses", n_com, 1);
      chk("t4_no_frame", n_frames, 4);
      chk("t4_value_held", value, 9876);

      scan(4, 3, 2, 1, 4'b0000, 1'b0);
      fnd_com = 4'hF;
      fnd_data = 8'hFF;
      for (int k = 0; k < 1200; k++) begin
         if (cyc >= fv_cyc + TMO - 1) break;
         @(negedge clk);
      end
      chk("t5_reach", cyc, fv_cyc + TMO - 1);
      chk("t5_stale_before", stale, 0);
      @(negedge clk);
      chk("t5_stale_at", stale, 1);
      slot(4'hF, 8'hFF, 20);
      chk("t5_stale_held", stale, 1);
      scan(4, 3, 2, 1, 4'b0000, 1'b0);
      chk("t5_stale_clear", stale, 0);
      chk("t5_changed", last_vc, 0);
      chk("t5_frames", n_frames, 6);

      slot(4'hE, 8'hC0, 20);
      slot(4'hD, 8'hC0, 20);
      do_reset();
      chk("t6_rst_value", value, 0);
      chk("t6_rst_bcd", digit_bcd, 0);
      chk("t6_rst_err", err_cnt, 0);
      scan(9, 0, 0, 0, 4'b0000, 1'b0);
      slot(4'hF, 8'hFF, 10);
      chk("t6_value", value, 9000);
      chk("t6_changed", last_vc, 1);

      chk("frames_pending", exp_q.size(), 0);
      chk("seg_total", n_seg, 1);
      chk("com_total", n_com, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
